// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM state type and iteration-counter sizing for mul_div_unit
package mdu_pkg;
    typedef enum logic [1:0] {MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11} op_t;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
    function automatic logic is_div(input op_t o);
        return o inside {DIVU, DIV};
    endfunction
    function automatic logic is_signed(input op_t o);
        return o inside {MULT, DIV};
    endfunction
endpackage

// File: rtl/cond_neg.sv
// cond_neg: two's-complement negate when en is set, pass-through otherwise
module cond_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic         en,
    output logic [W-1:0] y
);
    assign y = en ? -x : x;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed/unsigned multiply and restoring divide sharing one adder and counter
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    localparam int CW = cnt_width(WIDTH);
    state_t state, state_n;
    op_t op_in, op_r;
    logic [WIDTH-1:0] acc, q, bm, a_raw, a_mag, b_mag, q_fix, r_fix;
    logic [2*WIDTH-1:0] p_fix;
    logic [WIDTH:0] x, y, sum;
    logic [CW-1:0] cnt;
    logic sa, sb, neg_q, neg_r, dz, div_op;
    assign op_in  = op_t'(op);
    assign sa     = is_signed(op_in) & a[WIDTH-1];
    assign sb     = is_signed(op_in) & b[WIDTH-1];
    assign div_op = is_div(op_r);
    assign busy   = state != IDLE;
    cond_neg #(.W(WIDTH)) u_amag (.x(a), .en(sa), .y(a_mag));
    cond_neg #(.W(WIDTH)) u_bmag (.x(b), .en(sb), .y(b_mag));
    cond_neg #(.W(2*WIDTH)) u_pfix (.x({acc, q}), .en(neg_q), .y(p_fix));
    cond_neg #(.W(WIDTH)) u_qfix (.x(q), .en(neg_q), .y(q_fix));
    cond_neg #(.W(WIDTH)) u_rfix (.x(acc), .en(neg_r), .y(r_fix));
    // Divide shifts the next dividend bit into the partial remainder; its top sum bit is the borrow.
    assign x   = div_op ? {acc, q[WIDTH-1]} : {1'b0, acc};
    assign y   = (div_op || q[0]) ? {1'b0, bm} : '0;
    assign sum = div_op ? x - y : x + y;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? CALC : IDLE;
            CALC:    state_n = (cnt == CW'(1)) ? FIX : CALC;
            FIX:     state_n = DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= state == DONE;
            case (state)
                IDLE: if (start) begin
                    op_r     <= op_in;
                    acc      <= '0;
                    bm       <= is_div(op_in) ? b_mag : a_mag;
                    q        <= is_div(op_in) ? a_mag : b_mag;
                    cnt      <= CW'(WIDTH);
                    neg_q    <= sa ^ sb;
                    neg_r    <= sa;
                    dz       <= is_div(op_in) && b == '0;
                    a_raw    <= a;
                    div_zero <= 1'b0;
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    acc <= div_op ? (sum[WIDTH] ? x[WIDTH-1:0] : sum[WIDTH-1:0]) : sum[WIDTH:1];
                    q   <= div_op ? {q[WIDTH-2:0], ~sum[WIDTH]} : {sum[0], q[WIDTH-1:1]};
                end
                FIX: {acc, q} <= div_op ? {r_fix, q_fix} : p_fix;
                default: begin
                    hi       <= dz ? a_raw : acc;
                    lo       <= dz ? '1 : q;
                    div_zero <= dz;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vector table plus busy-start and mid-op reset sequences
module tb_mul_div_unit;
    logic clk, rst, start, busy, done, div_zero;
    logic [1:0] op;
    logic [31:0] a, b, hi, lo;
    int nchk = 0, nfail = 0, lat;
    logic got;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dz;
    } vec_t;
    vec_t v[14];

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input string nm);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            got = done;
        end
        if (!got) begin
            nchk++;
            nfail++;
            $display("FAIL %s timeout: no done within %0d cycles", nm, lat);
        end
    endtask

    task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] ai, input logic [31:0] bi);
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = ai;
        b = bi;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
        wait_done(nm);
    endtask

    initial begin
        v[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        v[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        v[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        v[3]  = '{2'b10, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
        v[4]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        v[5]  = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        v[6]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        v[7]  = '{2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
        v[8]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        v[9]  = '{2'b11, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        v[10] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        v[11] = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        v[12] = '{2'b01, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0};
        v[13] = '{2'b10, 32'h00000005, 32'h0000000A, 32'h00000005, 32'h00000000, 1'b0};

        rst = 1'b1;
        start = 1'b1;
        op = 2'b00;
        a = 32'd9;
        b = 32'd9;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        chk("reset div_zero", div_zero, 0);
        start = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle busy", busy, 0);

        for (int i = 0; i < 14; i++) begin
            do_op($sformatf("v%0d", i), v[i].op, v[i].a, v[i].b);
            chk($sformatf("v%0d latency", i), lat, 34);
            chk($sformatf("v%0d hi", i), hi, v[i].hi);
            chk($sformatf("v%0d lo", i), lo, v[i].lo);
            chk($sformatf("v%0d div_zero", i), div_zero, v[i].dz);
            chk($sformatf("v%0d busy at done", i), busy, 0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d done pulse width", i), done, 0);
            chk($sformatf("v%0d div_zero held", i), div_zero, v[i].dz);
            chk($sformatf("v%0d hi held", i), hi, v[i].hi);
        end

        // Starts with fresh operands while busy must be ignored
        @(negedge clk);
        start = 1'b1;
        op = 2'b00;
        a = 32'd3;
        b = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            got = done;
            if (lat == 5 || lat == 20) begin
                chk($sformatf("busy at cycle %0d", lat), busy, 1);
                start = 1'b1;
                op = 2'b10;
                a = 32'd99;
                b = 32'd3;
            end else begin
                start = 1'b0;
            end
        end
        if (!got) begin
            nchk++;
            nfail++;
            $display("FAIL busy-start timeout: no done within %0d cycles", lat);
        end
        chk("busy-start latency", lat, 34);
        chk("busy-start hi", hi, 0);
        chk("busy-start lo", lo, 15);
        do_op("back-to-back", 2'b00, 32'd6, 32'd7);
        chk("back-to-back latency", lat, 34);
        chk("back-to-back lo", lo, 42);
        chk("back-to-back hi", hi, 0);

        // Reset mid-divide abandons the operation
        @(negedge clk);
        start = 1'b1;
        op = 2'b10;
        a = 32'd1000;
        b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst hi", hi, 0);
        chk("rst lo", lo, 0);
        got = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            got = got | done;
        end
        chk("no done after rst", got, 0);
        chk("lo held after rst", lo, 0);
        do_op("after rst", 2'b10, 32'd1000, 32'd3);
        chk("after rst latency", lat, 34);
        chk("after rst lo", lo, 333);
        chk("after rst hi", hi, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand width, result halves and iteration count (legal range 4..64).
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 start  input  1  SHALL request an operation; sampled only in IDLE.
REQ-005 op  input  2  SHALL select the operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 a  input  WIDTH  SHALL carry the multiplicand or dividend.
REQ-007 b  input  WIDTH  SHALL carry the multiplier or divisor.
REQ-008 hi  output  WIDTH  SHALL carry the product upper half or the remainder.
REQ-009 lo  output  WIDTH  SHALL carry the product lower half or the quotient.
REQ-010 busy  output  1  SHALL be high while an operation is in flight.
REQ-011 done  output  1  SHALL be a one-cycle completion pulse.
REQ-012 div_zero  output  1  SHALL flag a divide with b==0; valid with done, held until the next accepted start.

Function
REQ-013 FSM states SHALL be IDLE, CALC, FIX, DONE.
REQ-014 IDLE with start=1 SHALL capture op, a and b into internal registers, set busy, clear div_zero and enter CALC; a, b and op SHALL be don't-care after that edge.
REQ-015 Signed ops SHALL convert operands to magnitudes at capture and record result signs: product/quotient negative iff sign(a)!=sign(b); remainder sign SHALL follow a.
REQ-016 CALC SHALL run exactly WIDTH cycles: shift-add multiply (one multiplier bit per cycle) or restoring divide (one quotient bit per cycle).
REQ-017 FIX SHALL last one cycle and apply recorded sign corrections (2WIDTH-bit negate for product; WIDTH-bit negates for quotient and remainder).
REQ-018 DONE SHALL last one cycle: hi/lo update, done=1, busy=0; next state IDLE.
REQ-019 Latency: done SHALL be asserted exactly WIDTH+2 cycles after the edge that accepts start.
REQ-020 A start may be accepted in the IDLE cycle immediately following DONE (back-to-back throughput WIDTH+3 cycles).
REQ-021 start while busy SHALL be ignored, with no effect on state, operands or outputs.
REQ-022 hi/lo SHALL change only in DONE; between operations they hold the last result.
REQ-023 Divide with b==0 SHALL keep full latency, assert div_zero, and return lo=all ones, hi=a (original, unsigned-interpreted bits), with no sign correction.
REQ-024 DIV of most-negative by -1 SHALL return lo=most-negative (wrap), hi=0, div_zero=0, and no other flag.
REQ-025 MULT/MULTU SHALL produce the exact 2WIDTH-bit product; div_zero SHALL stay 0.

Reset
REQ-026 rst=1 SHALL force IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0 at the next edge and SHALL take priority over start.
REQ-027 rst during CALC/FIX/DONE SHALL abandon the operation with no done pulse and no hi/lo update beyond the reset values.

Structure
REQ-028 Op encodings, the FSM state type and the iteration-counter width ($clog2(WIDTH+1)) SHALL live in the shared package mdu_pkg.
REQ-029 One sub-module, cond_neg (parameterised width; output = en ? -x : x), SHALL be used for operand magnitudes and result sign fix.
REQ-030 A single iteration counter and a single shared WIDTH+1-bit adder/subtractor SHALL serve both multiply and divide.

Verification (WIDTH=32)
REQ-031 MULTU a=FFFFFFFF b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001, done exactly 34 cycles after start accepted.
REQ-032 MULT a=FFFFFFFD(-3) b=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1; DIV a=FFFFFFF9(-7) b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-033 DIVU a=00000064 b=00000000 -> div_zero=1, lo=FFFFFFFF, hi=00000064, latency 34.
REQ-034 DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=00000000, div_zero=0.
REQ-035 start pulses with new operands at cycles 5 and 20 of a running op -> ignored, original result returned; start the cycle after done -> accepted.
REQ-036 rst asserted 10 cycles into a DIVU -> next edge busy=0, done=0, hi=lo=0, no later done pulse; a subsequent op completes normally.
